ycr_dmem_wb_bridge: RTL

Downstream stage of the data-memory router. Terminates one router port (portN_* dmem-style req/ack/resp interface) and converts each accepted transfer into a single classic Wishbone B4 master cycle. Performs byte-lane steering and alignment checks, and supports a bus timeout. One transfer is outstanding at a time. A new request can be accepted in the same cycle the response is returned, so back-to-back traffic is not stalled.

---
 rtl/ycr_dmem_wb_bridge_pkg.sv | 29 ++
 rtl/ycr_dmem_wb_lane.sv | 45 ++++
 rtl/ycr_dmem_wb_bridge.sv | 128 ++++++++++++
 3 files changed

// File: rtl/ycr_dmem_wb_bridge_pkg.sv
// rtl/ycr_dmem_wb_bridge_pkg.sv - memif encodings and bus widths shared by the dmem Wishbone bridge
`ifndef YCR_DMEM_AWIDTH
`define YCR_DMEM_AWIDTH 32
`endif
`ifndef YCR_DMEM_DWIDTH
`define YCR_DMEM_DWIDTH 32
`endif

package ycr_dmem_wb_bridge_pkg;

    typedef enum logic {
        YCR_MEM_CMD_RD = 1'b0,
        YCR_MEM_CMD_WR = 1'b1
    } type_ycr_mem_cmd_e;

    typedef enum logic [1:0] {
        YCR_MEM_WIDTH_BYTE  = 2'b00,
        YCR_MEM_WIDTH_HWORD = 2'b01,
        YCR_MEM_WIDTH_WORD  = 2'b10,
        YCR_MEM_WIDTH_ERROR = 2'b11
    } type_ycr_mem_width_e;

    typedef enum logic [1:0] {
        YCR_MEM_RESP_NOTRDY = 2'b00,
        YCR_MEM_RESP_RDY_OK = 2'b01,
        YCR_MEM_RESP_RDY_ER = 2'b10
    } type_ycr_mem_resp_e;

endpackage

// File: rtl/ycr_dmem_wb_lane.sv
// rtl/ycr_dmem_wb_lane.sv - byte-lane steering, read extraction and alignment check
module ycr_dmem_wb_lane
    import ycr_dmem_wb_bridge_pkg::*;
(
    input  logic [1:0]  width,
    input  logic [1:0]  off,
    input  logic [31:0] wdata,
    input  logic [31:0] bus_rdata,
    output logic [3:0]  sel,
    output logic [31:0] wdat,
    output logic [31:0] rdata,
    output logic        bad
);

    logic [31:0] shifted;

    assign shifted = bus_rdata >> {off, 3'b000};

    always_comb begin
        sel   = 4'b0000;
        wdat  = wdata;
        rdata = 32'h0;
        bad   = 1'b0;
        case (width)
            YCR_MEM_WIDTH_BYTE: begin
                sel   = 4'b0001 << off;
                wdat  = {4{wdata[7:0]}};
                rdata = {24'h0, shifted[7:0]};
            end
            YCR_MEM_WIDTH_HWORD: begin
                sel   = 4'b0011 << off;
                wdat  = {2{wdata[15:0]}};
                rdata = {16'h0, shifted[15:0]};
                bad   = off[0];
            end
            YCR_MEM_WIDTH_WORD: begin
                sel   = 4'hF;
                rdata = shifted;
                bad   = (off != 2'b00);
            end
            default: bad = 1'b1;
        endcase
    end

endmodule

// File: rtl/ycr_dmem_wb_bridge.sv
// rtl/ycr_dmem_wb_bridge.sv - dmem router port to single-beat classic Wishbone master
module ycr_dmem_wb_bridge
    import ycr_dmem_wb_bridge_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic                        clk,
    input  logic                        rst,
    output logic                        dmem_req_ack,
    input  logic                        dmem_req,
    input  logic                        dmem_cmd,
    input  logic [1:0]                  dmem_width,
    input  logic [`YCR_DMEM_AWIDTH-1:0] dmem_addr,
    input  logic [`YCR_DMEM_DWIDTH-1:0] dmem_wdata,
    output logic [`YCR_DMEM_DWIDTH-1:0] dmem_rdata,
    output logic [1:0]                  dmem_resp,
    output logic                        wbm_cyc_o,
    output logic                        wbm_stb_o,
    output logic                        wbm_we_o,
    output logic [31:0]                 wbm_adr_o,
    output logic [3:0]                  wbm_sel_o,
    output logic [31:0]                 wbm_dat_o,
    input  logic [31:0]                 wbm_dat_i,
    input  logic                        wbm_ack_i,
    input  logic                        wbm_err_i
);

    localparam int CW = $clog2(TIMEOUT_CYCLES + 1);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_BUS,
        ST_RESP
    } type_ycr_wbb_fsm_e;

    type_ycr_wbb_fsm_e state;
    logic [CW-1:0]     cnt;
    logic              req_cmd;
    logic [1:0]        req_width;
    logic [1:0]        req_off;

    logic [1:0]  lane_width;
    logic [1:0]  lane_off;
    logic [3:0]  lane_sel;
    logic [31:0] lane_wdat;
    logic [31:0] lane_rdata;
    logic        lane_bad;

    assign dmem_req_ack = ~rst & (state != ST_BUS);

    // Outside BUS the lane logic decodes the incoming request; inside BUS it
    // decodes the latched one so read data can be extracted on ack.
    assign lane_width = (state == ST_BUS) ? req_width : dmem_width;
    assign lane_off   = (state == ST_BUS) ? req_off   : dmem_addr[1:0];

    ycr_dmem_wb_lane u_lane (
        .width     (lane_width),
        .off       (lane_off),
        .wdata     (dmem_wdata),
        .bus_rdata (wbm_dat_i),
        .sel       (lane_sel),
        .wdat      (lane_wdat),
        .rdata     (lane_rdata),
        .bad       (lane_bad)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= ST_IDLE;
            cnt        <= '0;
            req_cmd    <= 1'b0;
            req_width  <= 2'b00;
            req_off    <= 2'b00;
            dmem_rdata <= '0;
            dmem_resp  <= YCR_MEM_RESP_NOTRDY;
            wbm_cyc_o  <= 1'b0;
            wbm_stb_o  <= 1'b0;
            wbm_we_o   <= 1'b0;
            wbm_adr_o  <= 32'h0;
            wbm_sel_o  <= 4'h0;
            wbm_dat_o  <= 32'h0;
        end else begin
            dmem_resp  <= YCR_MEM_RESP_NOTRDY;
            dmem_rdata <= '0;
            case (state)
                ST_BUS: begin
                    if (wbm_err_i || wbm_ack_i || (cnt == CW'(TIMEOUT_CYCLES - 1))) begin
                        wbm_cyc_o <= 1'b0;
                        wbm_stb_o <= 1'b0;
                        state     <= ST_RESP;
                        if (!wbm_err_i && wbm_ack_i) begin
                            dmem_resp <= YCR_MEM_RESP_RDY_OK;
                            if (req_cmd == YCR_MEM_CMD_RD)
                                dmem_rdata <= lane_rdata;
                        end else begin
                            dmem_resp <= YCR_MEM_RESP_RDY_ER;
                        end
                    end else begin
                        cnt <= cnt + CW'(1);
                    end
                end
                default: begin
                    if (dmem_req) begin
                        req_cmd   <= dmem_cmd;
                        req_width <= dmem_width;
                        req_off   <= dmem_addr[1:0];
                        if (lane_bad) begin
                            state     <= ST_RESP;
                            dmem_resp <= YCR_MEM_RESP_RDY_ER;
                        end else begin
                            state     <= ST_BUS;
                            cnt       <= '0;
                            wbm_cyc_o <= 1'b1;
                            wbm_stb_o <= 1'b1;
                            wbm_we_o  <= dmem_cmd;
                            wbm_adr_o <= {dmem_addr[31:2], 2'b00};
                            wbm_sel_o <= lane_sel;
                            wbm_dat_o <= lane_wdat;
                        end
                    end else begin
                        state <= ST_IDLE;
                    end
                end
            endcase
        end
    end

endmodule
